// File: rtl/data_mem_responder_if.sv
// Request/response bundle between a load/store initiator and the data memory responder.
// Latency: none, this file only groups wires.
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Initiator side
  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side
  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory serving RV32I byte/half/word loads and stores, one request in flight.
// Latency: first rsp_valid cycle is WAIT_STATES+1 cycles after accept; response held until rsp_ready.
// Backpressure: req_ready only in IDLE; macro DMEM_RESP_ERR_EN enables alignment/range/func3 error checks.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  data_mem_responder_if.slave  io_bus
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_accept;
  logic        w_enter_resp;
  logic        w_commit;

  // Fields of the access being performed this cycle
  logic        w_a_write;
  logic [2:0]  w_a_func3;
  logic [31:0] w_a_addr;
  logic [31:0] w_a_wdata;

  logic [1:0]    w_size;      // 0 byte, 1 half, 2 word
  logic          w_f3_ok;
  logic          w_err;
  logic [1:0]    w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic          w_sext;
  logic [31:0]   w_ld;
  logic [31:0]   w_rd_result;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wdat;

  assign w_accept = io_bus.req_valid && w_req_ready;
  assign w_enter_resp = (r_state == S_IDLE && w_accept && ZERO_WAIT) ||
                        (r_state == S_WAIT && r_cnt == 4'd0);
  // Reset on the commit edge must suppress the store as well as the state change
  assign w_commit = w_enter_resp && w_a_write && !w_err && i_rst;

  // With no wait states the access happens on the accept edge, so use the live request
  always_comb begin
    if (r_state == S_IDLE) begin
      w_a_write = io_bus.req_write;
      w_a_func3 = io_bus.req_func3;
      w_a_addr  = io_bus.req_addr;
      w_a_wdata = io_bus.req_wdata;
    end else begin
      w_a_write = r_write;
      w_a_func3 = r_func3;
      w_a_addr  = r_addr;
      w_a_wdata = r_wdata;
    end
  end

  // Decode access size, validity, error and byte offset
  always_comb begin
    w_size  = 2'd2;
    w_f3_ok = 1'b1;
    case (w_a_func3)
      3'b000:  w_size = 2'd0;
      3'b001:  w_size = 2'd1;
      3'b010:  w_size = 2'd2;
      3'b100:  begin w_size = 2'd0; w_f3_ok = !w_a_write; end
      3'b101:  begin w_size = 2'd1; w_f3_ok = !w_a_write; end
      default: w_f3_ok = 1'b0;
    endcase
    // An unlisted encoding behaves as a word access when errors are not reported
    if (!w_f3_ok) w_size = 2'd2;
`ifdef DMEM_RESP_ERR_EN
    w_err = !w_f3_ok ||
            (w_size == 2'd1 && w_a_addr[0]) ||
            (w_size == 2'd2 && w_a_addr[1:0] != 2'b00) ||
            ({2'b00, w_a_addr[31:2]} >= 32'(DEPTH_WORDS));
`else
    w_err = 1'b0;
`endif
    // Low address bits below the access size are ignored (force-align)
    case (w_size)
      2'd0:    w_off = w_a_addr[1:0];
      2'd1:    w_off = {w_a_addr[1], 1'b0};
      default: w_off = 2'b00;
    endcase
    w_idx = AW'({2'b00, w_a_addr[31:2]} % 32'(DEPTH_WORDS));
  end

  // Load extraction, store lane mask and lane-aligned store data
  always_comb begin
    w_word  = r_mem[w_idx];
    w_shift = w_word >> {w_off, 3'b000};
    w_sext  = !w_a_func3[2];
    case (w_size)
      2'd0:    w_ld = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_ld = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
      default: w_ld = w_shift;
    endcase
    w_rd_result = (w_a_write || w_err) ? 32'd0 : w_ld;
    case (w_size)
      2'd0:    w_wmask = 4'b0001 << w_off;
      2'd1:    w_wmask = 4'b0011 << w_off;
      default: w_wmask = 4'b1111;
    endcase
    w_wdat = w_a_wdata << {w_off, 3'b000};
  end

  // Storage: byte-lane writes on the edge entering RESP, never cleared by reset
  always_ff @(posedge i_clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = ZERO_WAIT ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:  if (io_bus.rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    w_req_ready = (r_state == S_IDLE);
    w_rsp_valid = (r_state == S_RESP);
  end

  // Wait counter: loaded on accept, counts down through WAIT
  always_ff @(posedge i_clk) begin
    if (!i_rst)                              r_cnt <= 4'd0;
    else if (w_accept)                       r_cnt <= CNT_LOAD;
    else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Request capture on accept
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_write <= 1'b0;
      r_func3 <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_accept) begin
      r_write <= io_bus.req_write;
      r_func3 <= io_bus.req_func3;
      r_addr  <= io_bus.req_addr;
      r_wdata <= io_bus.req_wdata;
    end
  end

  // Response registers: loaded once on entry to RESP, then held while stalled
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= w_rd_result;
      r_err   <= w_err;
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
// Expected values are hand-computed; DMEM_RESP_ERR_EN selects the error-reporting expectations.
// Outputs sampled on the falling edge, inputs driven after the rising edge.
module tb_data_mem_responder;

`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] ex;
  } vec_t;

  // One full request/response on the WAIT_STATES=2 instance; lat counts cycles from accept to rsp_valid
  task automatic transact(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string name,
                          output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    bus.req_write = wr;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 50);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    n_cmp++;
    if (bus.rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_rsp_valid: got %b, want 1", name, bus.rsp_valid);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    n_cmp++;
    if (bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rsp: rdata=%h err=%b, want 00000000 0", bus.rsp_rdata, bus.rsp_err);
    end
    n_cmp++;
    if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs0: req_ready=%b rsp_valid=%b, want 1 0", bus0.req_ready, bus0.rsp_valid);
    end
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic        er;
    int          lat;
    transact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw10", rd, er, lat);
    n_cmp++;
    if (rd !== 32'd0 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL sw10_rsp: rdata=%h err=%b, want 00000000 0", rd, er);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL sw10_latency: got %0d, want 3", lat);
    end
    transact(1'b0, 3'b010, 32'h10, 32'h0, "lw10", rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lw10_rsp: rdata=%h err=%b, want deadbeef 0", rd, er);
    end
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL lw10_latency: got %0d, want 3", lat);
    end
  endtask

  task automatic test_byte_half();
    vec_t        tbl [14];
    logic [31:0] rd;
    logic        er;
    int          lat;
    tbl[0]  = '{1'b1, 3'b000, 32'h11, 32'h0000007F, 32'h00000000};
    tbl[1]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'h0000007F};
    tbl[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE};
    tbl[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD};
    tbl[4]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD7FEF};
    tbl[5]  = '{1'b0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF};
    tbl[6]  = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h00007FEF};
    tbl[7]  = '{1'b1, 3'b010, 32'h14, 32'h11223344, 32'h00000000};
    tbl[8]  = '{1'b1, 3'b001, 32'h16, 32'hFFFFA5C3, 32'h00000000};
    tbl[9]  = '{1'b0, 3'b010, 32'h14, 32'h0,        32'hA5C33344};
    tbl[10] = '{1'b0, 3'b001, 32'h16, 32'h0,        32'hFFFFA5C3};
    tbl[11] = '{1'b0, 3'b100, 32'h17, 32'h0,        32'h000000A5};
    tbl[12] = '{1'b1, 3'b000, 32'h14, 32'hFFFFFFAB, 32'h00000000};
    tbl[13] = '{1'b0, 3'b010, 32'h14, 32'h0,        32'hA5C333AB};
    for (int i = 0; i < 14; i++) begin
      transact(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, $sformatf("bh%0d", i), rd, er, lat);
      n_cmp++;
      if (rd !== tbl[i].ex || er !== 1'b0) begin
        n_bad++;
        $display("FAIL bh%0d: rdata=%h err=%b, want %h 0", i, rd, er, tbl[i].ex);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rd;
    logic        er;
    int          lat;
    @(negedge clk);
    bus.req_write = 1'b0;
    bus.req_func3 = 3'b010;
    bus.req_addr  = 32'h10;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 50);
    n_cmp++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD7FEF) begin
      n_bad++;
      $display("FAIL stall_first: valid=%b rdata=%h, want 1 dead7fef", bus.rsp_valid, bus.rsp_rdata);
    end
    // A competing store presented while the response is stalled
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h0;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD7FEF || bus.req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: valid=%b rdata=%h req_ready=%b, want 1 dead7fef 0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    transact(1'b0, 3'b010, 32'h10, 32'h0, "stall_after", rd, er, lat);
    n_cmp++;
    if (rd !== 32'hDEAD7FEF) begin
      n_bad++;
      $display("FAIL stall_after: rdata=%h, want dead7fef", rd);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        seen;
    transact(1'b1, 3'b010, 32'h20, 32'h0BADF00D, "abort_pre", rd, er, lat);
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_func3 = 3'b010;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_cmp++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: req_ready=%b rsp_valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_rsp: rsp_valid seen=%b, want 0", seen);
    end
    transact(1'b0, 3'b010, 32'h20, 32'h0, "abort_lw", rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0BADF00D) begin
      n_bad++;
      $display("FAIL abort_lw: rdata=%h, want 0badf00d", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    transact(1'b0, 3'b010, 32'h12, 32'h0, "lw12", rd, er, lat);
    n_cmp++;
    if (rd !== (ERR_EN ? 32'h0 : 32'hDEAD7FEF) || er !== ERR_EN) begin
      n_bad++;
      $display("FAIL lw12: rdata=%h err=%b, want %h %b", rd, er,
               ERR_EN ? 32'h0 : 32'hDEAD7FEF, ERR_EN);
    end
    transact(1'b0, 3'b001, 32'h13, 32'h0, "lh13", rd, er, lat);
    n_cmp++;
    if (rd !== (ERR_EN ? 32'h0 : 32'hFFFFDEAD) || er !== ERR_EN) begin
      n_bad++;
      $display("FAIL lh13: rdata=%h err=%b, want %h %b", rd, er,
               ERR_EN ? 32'h0 : 32'hFFFFDEAD, ERR_EN);
    end
    transact(1'b0, 3'b011, 32'h10, 32'h0, "f3_011", rd, er, lat);
    n_cmp++;
    if (rd !== (ERR_EN ? 32'h0 : 32'hDEAD7FEF) || er !== ERR_EN) begin
      n_bad++;
      $display("FAIL f3_011: rdata=%h err=%b, want %h %b", rd, er,
               ERR_EN ? 32'h0 : 32'hDEAD7FEF, ERR_EN);
    end
    transact(1'b1, 3'b010, 32'h0, 32'h01020304, "sw0", rd, er, lat);
    transact(1'b1, 3'b010, 32'h1000, 32'hCAFEF00D, "sw1000", rd, er, lat);
    n_cmp++;
    if (rd !== 32'h0 || er !== ERR_EN) begin
      n_bad++;
      $display("FAIL sw1000: rdata=%h err=%b, want 00000000 %b", rd, er, ERR_EN);
    end
    transact(1'b0, 3'b010, 32'h0, 32'h0, "lw0", rd, er, lat);
    n_cmp++;
    if (rd !== (ERR_EN ? 32'h01020304 : 32'hCAFEF00D) || er !== 1'b0) begin
      n_bad++;
      $display("FAIL lw0: rdata=%h err=%b, want %h 0", rd, er,
               ERR_EN ? 32'h01020304 : 32'hCAFEF00D);
    end
  endtask

  // WAIT_STATES=0: four stores then four loads, request held valid, rsp_ready held high
  task automatic test_back_to_back();
    int          k;
    logic [31:0] ex;
    @(negedge clk);
    bus0.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      k = i / 2;
      n_cmp++;
      if (i % 2 == 0) begin
        if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b%0d: req_ready=%b rsp_valid=%b, want 1 0", i, bus0.req_ready, bus0.rsp_valid);
        end
        bus0.req_write = (k < 4);
        bus0.req_func3 = 3'b010;
        bus0.req_addr  = 32'h40 + 32'(4 * (k % 4));
        bus0.req_wdata = 32'h11111111 * 32'((k % 4) + 1);
        bus0.req_valid = 1'b1;
      end else begin
        ex = (k < 4) ? 32'h0 : 32'h11111111 * 32'((k % 4) + 1);
        if (bus0.req_ready !== 1'b0 || bus0.rsp_valid !== 1'b1 || bus0.rsp_rdata !== ex) begin
          n_bad++;
          $display("FAIL b2b%0d: req_ready=%b rsp_valid=%b rdata=%h, want 0 1 %h",
                   i, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, ex);
        end
      end
    end
    bus0.req_valid = 1'b0;
    @(posedge clk);
    #1 bus0.rsp_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_func3 = 3'd0;
    bus.req_addr  = 32'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0;  bus0.req_write = 1'b0;  bus0.req_func3 = 3'd0;
    bus0.req_addr  = 32'd0; bus0.req_wdata = 32'd0; bus0.rsp_ready = 1'b0;
    test_reset();
    test_store_load();
    test_byte_half();
    test_stall();
    test_abort();
    test_errors();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
